commit_trace_queue: RTL and testbench
=====================================

// Module: commit_trace_queue
// PURPOSE
//   Collects per-cycle commit events from the dual-issue writeback and memory stages and buffers them.
//   Events are memory store, GPR write, FPR write and HI/LO write.
//   Up to N_SLOT events per cycle are compacted, in slot order, into a cycle-stamped FIFO.
//   The FIFO drains one record per cycle to the golden-trace checker over a valid/ready handshake.
//   Sits between trivial_mips commit outputs and the trace comparator.
//   Slot order = required report order: mem_a, gpr_a, fpr_a, hilo_a, mem_b, gpr_b, fpr_b, hilo_b.
// PARAMETERS
//   N_SLOT  8   event slots sampled per cycle; slot 0 is reported first
//   DEPTH   32  FIFO entries; power of two, DEPTH >= N_SLOT
//   TAG_W   16  tag width (byte address for MEM, register index for GPR/FPR, 0 for HILO)
//   DATA_W  64  payload width (32-bit values zero-extended; HILO = {hi,lo})
//   CYC_W   32  cycle stamp width
// PORTS
//   clk        in   1                 clock (clk.base)
//   rst        in   1                 synchronous active-high reset (clk.rst)
//   fpu_en     in   1                 1: keep FPR events; 0: drop them
//   in_valid   in   N_SLOT            per-slot event valid
//   in_kind    in   2*N_SLOT          per-slot kind: 0 MEM, 1 GPR, 2 FPR, 3 HILO
//   in_tag     in   TAG_W*N_SLOT      per-slot tag
//   in_data    in   DATA_W*N_SLOT     per-slot payload
//   out_valid  out  1                 head record present
//   out_ready  in   1                 consumer accepts head this cycle
//   out_kind   out  2                 head kind
//   out_tag    out  TAG_W             head tag
//   out_data   out  DATA_W            head payload
//   out_cycle  out  CYC_W             head cycle stamp
//   level      out  $clog2(DEPTH)+1   occupied entries
//   overflow   out  1                 sticky: a cycle's events were dropped
//   drop_cnt   out  16                events dropped; saturates at 16'hFFFF
// BEHAVIOUR
//   Reset (sync, highest priority): FIFO empty, level=0, out_valid=0, overflow=0, drop_cnt=0, cycle_q=0.
//     Head fields read 0 after reset.
//     Reset mid-stream discards all queued records; same-cycle inputs are ignored.
//   Cycle stamp: cycle_q increments by 1 every non-reset cycle and wraps at 2^CYC_W.
//     Events sampled in a cycle are stamped cycle_q+1, so the first cycle after reset stamps 1.
//   Filtering: slot s is accepted iff in_valid[s] and not (kind==GPR && tag==0) and not (kind==FPR && !fpu_en).
//   Compaction: accepted slots are written to consecutive entries from wr_ptr in ascending slot order, with no gaps.
//     Write pointer advances by popcount(accepted).
//   Space check: uses free = DEPTH - level from the start of the cycle; a same-cycle dequeue does not add space.
//     If popcount(accepted) > free, all events of that cycle are dropped (atomic, no partial write).
//     On such a drop: overflow <= 1; drop_cnt += popcount (saturating).
//   Output: show-ahead FIFO. out_* come directly from the head entry register.
//     out_valid = (level != 0).
//     Pop when out_valid && out_ready; out_ready while !out_valid has no effect.
//   Latency: an event sampled in cycle N appears at the head in cycle N+1 if the FIFO was empty.
//   Simultaneous enqueue and pop: level_next = level + accepted_count - pop. Pointers wrap modulo DEPTH.
//   Full (level==DEPTH): out_valid=1. Any accepted event that cycle overflows.
//   Zero accepted events: FIFO unchanged apart from a possible pop.
// TESTING
//   1 Reset, then idle 5 cycles -> out_valid=0, level=0, overflow=0.
//     The first event afterwards is stamped with its cycle index starting at 1.
//   2 Cycle 3: slots 0 (MEM tag 0x0010 data 0xDEADBEEF), 1 (GPR tag 2 data 0x1234) and 3 (HILO data 0x1_00000002) valid; out_ready=1.
//     -> cycles 4,5,6 present MEM, GPR, HILO in that order, all with out_cycle=3.
//   3 GPR slot with tag 0, plus FPR slot with fpu_en=0 -> nothing enqueued, level stays 0.
//     Same FPR slot with fpu_en=1 -> enqueued.
//   4 out_ready=0; 8 events/cycle for 4 cycles -> level=32.
//     5th cycle with 2 events -> dropped whole: overflow=1, drop_cnt=2, level=32, head unchanged.
//   5 level=31, 1 event and a pop in the same cycle -> level stays 31, order preserved.
//     Same state with 2 events -> both dropped, pop still happens, level=30.
//   6 Assert rst with level=10 -> next cycle level=0, out_valid=0, overflow=0; the stamp restarts at 1.

Source files
------------

// File: rtl/commit_trace_queue.sv
// Commit trace queue: filters and compacts up to N_SLOT commit events per cycle
// into a cycle-stamped show-ahead FIFO drained over a valid/ready handshake.
module commit_trace_queue #(
    parameter int N_SLOT = 8,
    parameter int DEPTH  = 32,
    parameter int TAG_W  = 16,
    parameter int DATA_W = 64,
    parameter int CYC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fpu_en,
    input  logic [N_SLOT-1:0]          in_valid,
    input  logic [2*N_SLOT-1:0]        in_kind,
    input  logic [TAG_W*N_SLOT-1:0]    in_tag,
    input  logic [DATA_W*N_SLOT-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_kind,
    output logic [TAG_W-1:0]           out_tag,
    output logic [DATA_W-1:0]          out_data,
    output logic [CYC_W-1:0]           out_cycle,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(N_SLOT) + 1;

    localparam logic [1:0] KIND_GPR = 2'd1;
    localparam logic [1:0] KIND_FPR = 2'd2;

    // Storage (no reset; the head is masked while empty)
    logic [1:0]        kind_mem  [DEPTH];
    logic [TAG_W-1:0]  tag_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem  [DEPTH];
    logic [CYC_W-1:0]  cycle_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0] level_reg, level_next;
    logic [CYC_W-1:0] cycle_reg, cycle_next;
    logic             overflow_reg, overflow_next;
    logic [15:0]      drop_cnt_reg, drop_cnt_next;

    logic [1:0]        slot_kind [N_SLOT];
    logic [TAG_W-1:0]  slot_tag  [N_SLOT];
    logic [DATA_W-1:0] slot_data [N_SLOT];
    logic [N_SLOT-1:0] accept;

    logic [CNT_W-1:0] slot_off [N_SLOT];
    logic [PTR_W-1:0] wr_idx   [N_SLOT];
    logic [CNT_W-1:0] acc_cnt;
    logic [LVL_W-1:0] free_cnt;
    logic             do_write;
    logic             do_drop;
    logic             pop;
    logic [16:0]      drop_sum;

    generate
        for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_slot
            assign slot_kind[gi] = in_kind[2*gi +: 2];
            assign slot_tag[gi]  = in_tag[TAG_W*gi +: TAG_W];
            assign slot_data[gi] = in_data[DATA_W*gi +: DATA_W];
            // Writes to $zero and FPR events with the FPU disabled never reach the trace
            assign accept[gi] = in_valid[gi]
                                && !(slot_kind[gi] == KIND_GPR && slot_tag[gi] == '0)
                                && !(slot_kind[gi] == KIND_FPR && !fpu_en);
        end
    endgenerate

    // Prefix count gives each accepted slot its gap-free offset from wr_ptr
    always_comb begin
        acc_cnt = '0;
        for (int s = 0; s < N_SLOT; s++) begin
            slot_off[s] = acc_cnt;
            wr_idx[s]   = wr_ptr_reg + PTR_W'(acc_cnt);
            acc_cnt     = acc_cnt + CNT_W'(accept[s]);
        end
    end

    assign out_valid = (level_reg != '0);
    assign pop       = out_valid && out_ready;
    // Space is judged on start-of-cycle occupancy; a same-cycle pop does not help
    assign free_cnt  = LVL_W'(DEPTH) - level_reg;
    assign do_write  = (acc_cnt != '0) && (LVL_W'(acc_cnt) <= free_cnt);
    assign do_drop   = (acc_cnt != '0) && (LVL_W'(acc_cnt) >  free_cnt);
    assign drop_sum  = {1'b0, drop_cnt_reg} + 17'(acc_cnt);

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        level_next    = level_reg;
        overflow_next = overflow_reg;
        drop_cnt_next = drop_cnt_reg;
        cycle_next    = cycle_reg + 1'b1;

        if (do_write) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(acc_cnt);
            level_next  = level_next + LVL_W'(acc_cnt);
        end
        if (do_drop) begin
            overflow_next = 1'b1;
            drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
            level_next  = level_next - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            cycle_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            cycle_reg    <= cycle_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Events sampled this cycle carry the stamp cycle_q+1
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            for (int s = 0; s < N_SLOT; s++) begin
                if (accept[s]) begin
                    kind_mem[wr_idx[s]]  <= slot_kind[s];
                    tag_mem[wr_idx[s]]   <= slot_tag[s];
                    data_mem[wr_idx[s]]  <= slot_data[s];
                    cycle_mem[wr_idx[s]] <= cycle_next;
                end
            end
        end
    end

    assign out_kind  = out_valid ? kind_mem[rd_ptr_reg]  : '0;
    assign out_tag   = out_valid ? tag_mem[rd_ptr_reg]   : '0;
    assign out_data  = out_valid ? data_mem[rd_ptr_reg]  : '0;
    assign out_cycle = out_valid ? cycle_mem[rd_ptr_reg] : '0;
    assign level     = level_reg;
    assign overflow  = overflow_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_commit_trace_queue.sv
// Directed bench for commit_trace_queue: filtering, compaction order, stamps,
// atomic overflow, same-cycle pop/enqueue and mid-stream reset.
module tb_commit_trace_queue;

    localparam int N_SLOT = 8;
    localparam int DEPTH  = 32;
    localparam int TAG_W  = 16;
    localparam int DATA_W = 64;
    localparam int CYC_W  = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     fpu_en;
    logic [N_SLOT-1:0]        in_valid;
    logic [2*N_SLOT-1:0]      in_kind;
    logic [TAG_W*N_SLOT-1:0]  in_tag;
    logic [DATA_W*N_SLOT-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [1:0]               out_kind;
    logic [TAG_W-1:0]         out_tag;
    logic [DATA_W-1:0]        out_data;
    logic [CYC_W-1:0]         out_cycle;
    logic [5:0]               level;
    logic                     overflow;
    logic [15:0]              drop_cnt;

    int n_pass = 0;
    int n_total = 0;

    commit_trace_queue #(
        .N_SLOT(N_SLOT), .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .rst(rst), .fpu_en(fpu_en),
        .in_valid(in_valid), .in_kind(in_kind), .in_tag(in_tag), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_tag(out_tag), .out_data(out_data), .out_cycle(out_cycle),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = '0;
        in_kind  = '0;
        in_tag   = '0;
        in_data  = '0;
    endtask

    task automatic set_slot(input int s, input logic [1:0] k, input logic [15:0] t,
                            input logic [63:0] d);
        in_valid[s]          = 1'b1;
        in_kind[2*s +: 2]    = k;
        in_tag[16*s +: 16]   = t;
        in_data[64*s +: 64]  = d;
    endtask

    task automatic do_reset();
        clear_inputs();
        out_ready = 1'b0;
        fpu_en    = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (out_valid !== 1'b0 || level !== 6'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
            $display("FAIL reset_state got v=%b lvl=%0d ovf=%b drop=%0d want 0/0/0/0",
                     out_valid, level, overflow, drop_cnt);
        end else n_pass++;
        n_total++;
        if (out_kind !== 2'd0 || out_tag !== 16'd0 || out_data !== 64'd0 || out_cycle !== 32'd0) begin
            $display("FAIL reset_head got k=%0d t=%h d=%h c=%0d want zeros",
                     out_kind, out_tag, out_data, out_cycle);
        end else n_pass++;
        for (int i = 0; i < 5; i++) tick();
        n_total++;
        if (out_valid !== 1'b0 || level !== 6'd0 || overflow !== 1'b0) begin
            $display("FAIL idle_state got v=%b lvl=%0d ovf=%b want 0/0/0", out_valid, level, overflow);
        end else n_pass++;
        set_slot(1, 2'd1, 16'd5, 64'h55);
        tick();
        clear_inputs();
        n_total++;
        if (out_valid !== 1'b1 || out_cycle !== 32'd6 || out_kind !== 2'd1 || out_tag !== 16'd5 ||
            level !== 6'd1) begin
            $display("FAIL first_stamp got v=%b c=%0d k=%0d t=%0d lvl=%0d want 1/6/1/5/1",
                     out_valid, out_cycle, out_kind, out_tag, level);
        end else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total++;
        if (level !== 6'd0 || out_valid !== 1'b0) begin
            $display("FAIL first_pop got lvl=%0d v=%b want 0/0", level, out_valid);
        end else n_pass++;
    endtask

    task automatic test_compaction();
        do_reset();
        tick();
        tick();
        set_slot(0, 2'd0, 16'h0010, 64'hDEADBEEF);
        set_slot(1, 2'd1, 16'd2, 64'h1234);
        set_slot(3, 2'd3, 16'd0, 64'h1_00000002);
        out_ready = 1'b1;
        tick();
        clear_inputs();
        n_total++;
        if (out_kind !== 2'd0 || out_tag !== 16'h0010 || out_data !== 64'hDEADBEEF ||
            out_cycle !== 32'd3 || level !== 6'd3) begin
            $display("FAIL compact_mem got k=%0d t=%h d=%h c=%0d lvl=%0d want 0/0010/deadbeef/3/3",
                     out_kind, out_tag, out_data, out_cycle, level);
        end else n_pass++;
        tick();
        n_total++;
        if (out_kind !== 2'd1 || out_tag !== 16'd2 || out_data !== 64'h1234 ||
            out_cycle !== 32'd3 || level !== 6'd2) begin
            $display("FAIL compact_gpr got k=%0d t=%h d=%h c=%0d lvl=%0d want 1/0002/1234/3/2",
                     out_kind, out_tag, out_data, out_cycle, level);
        end else n_pass++;
        tick();
        n_total++;
        if (out_kind !== 2'd3 || out_tag !== 16'd0 || out_data !== 64'h1_00000002 ||
            out_cycle !== 32'd3 || level !== 6'd1) begin
            $display("FAIL compact_hilo got k=%0d t=%h d=%h c=%0d lvl=%0d want 3/0000/100000002/3/1",
                     out_kind, out_tag, out_data, out_cycle, level);
        end else n_pass++;
        tick();
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || level !== 6'd0) begin
            $display("FAIL compact_drain got v=%b lvl=%0d want 0/0", out_valid, level);
        end else n_pass++;
    endtask

    task automatic test_filter();
        do_reset();
        fpu_en = 1'b0;
        set_slot(1, 2'd1, 16'd0, 64'h11);
        set_slot(2, 2'd2, 16'd7, 64'h77);
        tick();
        n_total++;
        if (level !== 6'd0 || out_valid !== 1'b0 || drop_cnt !== 16'd0) begin
            $display("FAIL filter_off got lvl=%0d v=%b drop=%0d want 0/0/0", level, out_valid, drop_cnt);
        end else n_pass++;
        fpu_en = 1'b1;
        tick();
        clear_inputs();
        n_total++;
        if (level !== 6'd1 || out_kind !== 2'd2 || out_tag !== 16'd7 || out_data !== 64'h77) begin
            $display("FAIL filter_fpr got lvl=%0d k=%0d t=%0d d=%h want 1/2/7/77",
                     level, out_kind, out_tag, out_data);
        end else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            for (int s = 0; s < 8; s++) set_slot(s, 2'd0, 16'(16'h100 + c*8 + s), 64'(c*8 + s));
            tick();
            n_total++;
            if (level !== 6'(8*(c+1))) begin
                $display("FAIL fill_level got %0d want %0d", level, 8*(c+1));
            end else n_pass++;
        end
        clear_inputs();
        set_slot(0, 2'd1, 16'd1, 64'h1);
        set_slot(1, 2'd1, 16'd2, 64'h2);
        tick();
        clear_inputs();
        n_total++;
        if (overflow !== 1'b1 || drop_cnt !== 16'd2 || level !== 6'd32 || out_valid !== 1'b1) begin
            $display("FAIL full_drop got ovf=%b drop=%0d lvl=%0d v=%b want 1/2/32/1",
                     overflow, drop_cnt, level, out_valid);
        end else n_pass++;
        n_total++;
        if (out_tag !== 16'h100 || out_cycle !== 32'd1) begin
            $display("FAIL full_head got t=%h c=%0d want 0100/1", out_tag, out_cycle);
        end else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++;
        if (level !== 6'd31 || out_tag !== 16'h101) begin
            $display("FAIL full_pop got lvl=%0d t=%h want 31/0101", level, out_tag);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        set_slot(2, 2'd1, 16'd9, 64'h99);
        tick();
        clear_inputs();
        n_total++;
        if (level !== 6'd31 || out_tag !== 16'h102 || drop_cnt !== 16'd2) begin
            $display("FAIL b2b_fit got lvl=%0d t=%h drop=%0d want 31/0102/2", level, out_tag, drop_cnt);
        end else n_pass++;
        set_slot(0, 2'd1, 16'd3, 64'h3);
        set_slot(1, 2'd1, 16'd4, 64'h4);
        tick();
        clear_inputs();
        n_total++;
        if (level !== 6'd30 || out_tag !== 16'h103 || drop_cnt !== 16'd4 || overflow !== 1'b1) begin
            $display("FAIL b2b_drop got lvl=%0d t=%h drop=%0d ovf=%b want 30/0103/4/1",
                     level, out_tag, drop_cnt, overflow);
        end else n_pass++;
        for (int i = 0; i < 29; i++) begin
            n_total++;
            if (out_tag !== 16'(16'h103 + i)) begin
                $display("FAIL drain_order got t=%h want %h", out_tag, 16'(16'h103 + i));
            end else n_pass++;
            tick();
        end
        n_total++;
        if (level !== 6'd1 || out_kind !== 2'd1 || out_tag !== 16'd9 || out_data !== 64'h99 ||
            out_cycle !== 32'd7) begin
            $display("FAIL drain_tail got lvl=%0d k=%0d t=%0d d=%h c=%0d want 1/1/9/99/7",
                     level, out_kind, out_tag, out_data, out_cycle);
        end else n_pass++;
        tick();
        out_ready = 1'b0;
        n_total++;
        if (level !== 6'd0 || out_valid !== 1'b0) begin
            $display("FAIL drain_empty got lvl=%0d v=%b want 0/0", level, out_valid);
        end else n_pass++;
    endtask

    task automatic test_mid_reset();
        for (int s = 0; s < 8; s++) set_slot(s, 2'd1, 16'(s + 1), 64'(s + 1));
        tick();
        clear_inputs();
        set_slot(0, 2'd0, 16'h20, 64'h20);
        set_slot(1, 2'd0, 16'h21, 64'h21);
        tick();
        n_total++;
        if (level !== 6'd10 || overflow !== 1'b1) begin
            $display("FAIL pre_reset got lvl=%0d ovf=%b want 10/1", level, overflow);
        end else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        n_total++;
        if (level !== 6'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
            $display("FAIL mid_reset got lvl=%0d v=%b ovf=%b drop=%0d want 0/0/0/0",
                     level, out_valid, overflow, drop_cnt);
        end else n_pass++;
        set_slot(0, 2'd0, 16'h44, 64'h44);
        tick();
        clear_inputs();
        n_total++;
        if (level !== 6'd1 || out_cycle !== 32'd1 || out_tag !== 16'h44) begin
            $display("FAIL restamp got lvl=%0d c=%0d t=%h want 1/1/0044", level, out_cycle, out_tag);
        end else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        fpu_en = 1'b1;
        out_ready = 1'b0;
        clear_inputs();
        test_reset();
        test_compaction();
        test_filter();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
